// File: rtl/shadow_call_monitor_pkg.sv
// shadow_pkg: shared constants and enums for the shadow-stack call monitor.
// Holds the OpenRISC opcode values that matter for call/return tracking,
// the link register number, the alarm cause encoding and the FSM states.
package shadow_pkg;

  localparam int DATA_W = 32;

  localparam logic [5:0] OPC_JAL  = 6'h01;
  localparam logic [5:0] OPC_JALR = 6'h12;
  localparam logic [5:0] OPC_JR   = 6'h11;
  localparam logic [4:0] LINK_REG = 5'd9;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'b00,
    CAUSE_MISMATCH  = 2'b01,
    CAUSE_UNDERFLOW = 2'b10,
    CAUSE_OVERFLOW  = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    WAIT  = 2'd2,
    CHECK = 2'd3
  } state_e;

endpackage

// File: rtl/shadow_call_monitor_if.sv
// Bundle of commit-port, shadow-stack and alarm signals around the monitor.
// master: the monitor itself. slave: the environment (core, stack, alarm sink).
interface shadow_call_monitor_if #(
  parameter int DATA_W = 32
);
  logic              insn_valid_i;
  logic [31:0]       insn_i;
  logic [DATA_W-1:0] pc_i;
  logic [DATA_W-1:0] target_i;
  logic              busy_o;
  logic              stk_en_o;
  logic              stk_push_pop_o;
  logic [DATA_W-1:0] stk_data_o;
  logic [DATA_W-1:0] stk_data_i;
  logic              alarm_o;
  logic [1:0]        alarm_cause_o;
  logic [DATA_W-1:0] alarm_pc_o;
  logic [7:0]        depth_o;

  modport master (
    input  insn_valid_i, insn_i, pc_i, target_i, stk_data_i,
    output busy_o, stk_en_o, stk_push_pop_o, stk_data_o,
           alarm_o, alarm_cause_o, alarm_pc_o, depth_o
  );

  modport slave (
    output insn_valid_i, insn_i, pc_i, target_i, stk_data_i,
    input  busy_o, stk_en_o, stk_push_pop_o, stk_data_o,
           alarm_o, alarm_cause_o, alarm_pc_o, depth_o
  );
endinterface

// File: rtl/shadow_call_monitor_insn_decode.sv
// shadow_insn_decode: classifies a retired instruction word as a call
// (l.jal / l.jalr) or a return (l.jr through the link register r9).
module shadow_insn_decode
  import shadow_pkg::*;
(
  input  logic [31:0] insn,
  output logic        is_call,
  output logic        is_ret
);

  logic [5:0] opcode;
  logic [4:0] reg_b;
  logic       unused_bits;

  assign opcode      = insn[31:26];
  assign reg_b       = insn[15:11];
  assign unused_bits = ^{insn[25:16], insn[10:0]};

  // Opcode match; l.jr through any register other than r9 is not a return.
  always_comb begin
    is_call = (opcode == OPC_JAL) || (opcode == OPC_JALR);
    is_ret  = (opcode == OPC_JR) && (reg_b == LINK_REG);
  end

endmodule

// File: rtl/shadow_call_monitor.sv
// shadow_call_monitor: watches the retired-instruction stream, pushes link
// addresses on calls, pops and compares them on returns, and flags
// mismatch / underflow / overflow.
// Optional build macro: SHADOW_ALARM_LATCH_EN makes the alarm sticky until
// reset and keeps the first violation's cause and PC.
module shadow_call_monitor
  import shadow_pkg::*;
#(
  parameter int DEPTH       = 128,
  parameter int LINK_OFFSET = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  shadow_call_monitor_if.master  bus
);

  localparam logic [7:0]  DEPTH_MAX = 8'(DEPTH);
  localparam logic [31:0] LINK_OFS  = 32'(LINK_OFFSET);

  state_e      state;
  logic [31:0] ret_target;
  logic [31:0] ret_pc;
  logic [7:0]  depth;

  logic        is_call;
  logic        is_ret;
  logic        accept;

  logic        viol;
  cause_e      viol_cause;
  logic [31:0] viol_pc;

  shadow_insn_decode u_decode (
    .insn    (bus.insn_i),
    .is_call (is_call),
    .is_ret  (is_ret)
  );

  assign accept     = bus.insn_valid_i & ~bus.busy_o;
  assign bus.depth_o = depth;

  // Violation detection for this cycle: capacity checks in IDLE, compare in CHECK.
  always_comb begin
    viol       = 1'b0;
    viol_cause = CAUSE_NONE;
    viol_pc    = '0;
    if (state == IDLE && accept) begin
      if (is_call && depth == DEPTH_MAX) begin
        viol       = 1'b1;
        viol_cause = CAUSE_OVERFLOW;
        viol_pc    = bus.pc_i;
      end else if (is_ret && depth == 8'd0) begin
        viol       = 1'b1;
        viol_cause = CAUSE_UNDERFLOW;
        viol_pc    = bus.pc_i;
      end
    end else if (state == CHECK && bus.stk_data_i != ret_target) begin
      viol       = 1'b1;
      viol_cause = CAUSE_MISMATCH;
      viol_pc    = ret_pc;
    end
  end

  // Call/return FSM with registered stack strobes, stall and depth count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      depth              <= '0;
      ret_target         <= '0;
      ret_pc             <= '0;
      bus.busy_o         <= 1'b0;
      bus.stk_en_o       <= 1'b0;
      bus.stk_push_pop_o <= 1'b0;
      bus.stk_data_o     <= '0;
    end else begin
      bus.stk_en_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && is_call && depth != DEPTH_MAX) begin
            bus.stk_en_o       <= 1'b1;
            bus.stk_push_pop_o <= 1'b1;
            bus.stk_data_o     <= bus.pc_i + LINK_OFS;
            depth              <= depth + 8'd1;
          end else if (accept && is_ret && depth != 8'd0) begin
            ret_target         <= bus.target_i;
            ret_pc             <= bus.pc_i;
            bus.stk_en_o       <= 1'b1;
            bus.stk_push_pop_o <= 1'b0;
            bus.busy_o         <= 1'b1;
            state              <= POP;
          end
        end
        POP: begin
          depth <= depth - 8'd1;
          state <= WAIT;
        end
        WAIT: begin
          state <= CHECK;
        end
        CHECK: begin
          bus.busy_o <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Alarm reporting: sticky first-violation capture or per-violation pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.alarm_o       <= 1'b0;
      bus.alarm_cause_o <= CAUSE_NONE;
      bus.alarm_pc_o    <= '0;
    end else begin
`ifdef SHADOW_ALARM_LATCH_EN
      if (viol && !bus.alarm_o) begin
        bus.alarm_o       <= 1'b1;
        bus.alarm_cause_o <= viol_cause;
        bus.alarm_pc_o    <= viol_pc;
      end
`else
      bus.alarm_o <= viol;
      if (viol) begin
        bus.alarm_cause_o <= viol_cause;
        bus.alarm_pc_o    <= viol_pc;
      end
`endif
    end
  end

endmodule

// File: tb/tb_shadow_call_monitor.sv
// Scoreboard bench for shadow_call_monitor: a queue-based reference stack
// predicts stack operations and alarms; a monitor process compares them.
module tb_shadow_call_monitor;

  typedef struct {
    logic        push;
    logic [31:0] data;
  } op_t;

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] pc;
  } al_t;

  logic clk = 1'b0;
  logic reset;

  shadow_call_monitor_if bus ();

  shadow_call_monitor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mstk[$];
  op_t         exp_op[$];
  al_t         exp_al[$];

  // Environment: behavioural shadow stack responding to the DUT's strobes.
  logic [31:0] env_mem [0:255];
  int          env_sp;
  initial begin
    env_sp = 0;
    bus.stk_data_i = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        env_sp         <= 0;
        bus.stk_data_i <= '0;
      end else if (bus.stk_en_o) begin
        if (bus.stk_push_pop_o) begin
          if (env_sp < 256) env_mem[env_sp] <= bus.stk_data_o;
          env_sp <= env_sp + 1;
        end else if (env_sp > 0) begin
          bus.stk_data_i <= env_mem[env_sp-1];
          env_sp         <= env_sp - 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_jal(input logic [25:0] off);
    return {6'h01, off};
  endfunction
  function automatic logic [31:0] mk_jalr(input logic [4:0] rb);
    return {6'h12, 10'd0, rb, 11'd0};
  endfunction
  function automatic logic [31:0] mk_jr(input logic [4:0] rb);
    return {6'h11, 10'd0, rb, 11'd0};
  endfunction

  // Reference: calls push PC+8 up to 128 entries, r9 returns pop and compare.
  task automatic model_apply(input logic [31:0] insn, input logic [31:0] pc, input logic [31:0] tgt);
    logic [5:0]  opc;
    logic [31:0] top;
    opc = insn[31:26];
    if (opc == 6'h01 || opc == 6'h12) begin
      if (mstk.size() < 128) begin
        mstk.push_back(pc + 32'd8);
        exp_op.push_back('{push: 1'b1, data: pc + 32'd8});
      end else begin
        exp_al.push_back('{cause: 2'b11, pc: pc});
      end
    end else if (opc == 6'h11 && insn[15:11] == 5'd9) begin
      if (mstk.size() == 0) begin
        exp_al.push_back('{cause: 2'b10, pc: pc});
      end else begin
        top = mstk.pop_back();
        exp_op.push_back('{push: 1'b0, data: 32'd0});
        if (top != tgt) exp_al.push_back('{cause: 2'b01, pc: pc});
      end
    end
  endtask

  task automatic issue(input logic v, input logic [31:0] insn, input logic [31:0] pc, input logic [31:0] tgt);
    logic acc;
    @(negedge clk);
    bus.insn_valid_i = v;
    bus.insn_i       = insn;
    bus.pc_i         = pc;
    bus.target_i     = tgt;
    acc = v && !bus.busy_o;
    @(posedge clk);
    #1;
    bus.insn_valid_i = 1'b0;
    if (acc) model_apply(insn, pc, tgt);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy_o) begin
      errors++;
      checks++;
      $display("FAIL busy_timeout: busy_o still %0b after %0d cycles", bus.busy_o, n);
    end
  endtask

  function automatic logic [31:0] top_or_zero();
    if (mstk.size() == 0) return 32'd0;
    return mstk[$];
  endfunction

  // Monitor: pops expectations whenever the DUT strobes the stack or alarms.
  initial begin
    op_t op;
    al_t al;
    int  busy_run;
    busy_run = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_run = 0;
      end else begin
        if (bus.stk_en_o) begin
          if (exp_op.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_stk_en: push_pop %0b data %0h, expected no operation", bus.stk_push_pop_o, bus.stk_data_o);
          end else begin
            op = exp_op.pop_front();
            check("stk_push_pop", 32'(bus.stk_push_pop_o), 32'(op.push));
            if (op.push) check("stk_data", bus.stk_data_o, op.data);
          end
        end
        if (bus.alarm_o) begin
          if (exp_al.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_alarm: cause %0d pc %0h, expected no alarm", bus.alarm_cause_o, bus.alarm_pc_o);
          end else begin
            al = exp_al.pop_front();
            check("alarm_cause", 32'(bus.alarm_cause_o), 32'(al.cause));
            check("alarm_pc", bus.alarm_pc_o, al.pc);
          end
        end
        if (!bus.busy_o) check("depth_idle", 32'(bus.depth_o), 32'(mstk.size()));
        if (bus.busy_o) begin
          busy_run++;
        end else if (busy_run > 0) begin
          check("busy_cycles", 32'(busy_run), 32'd3);
          busy_run = 0;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [31:0] pc;
    reset = 1'b1;
    bus.insn_valid_i = 1'b0;
    bus.insn_i = '0;
    bus.pc_i = '0;
    bus.target_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_stk_en", 32'(bus.stk_en_o), 32'd0);
    check("rst_push_pop", 32'(bus.stk_push_pop_o), 32'd0);
    check("rst_stk_data", bus.stk_data_o, 32'd0);
    check("rst_alarm", 32'(bus.alarm_o), 32'd0);
    check("rst_cause", 32'(bus.alarm_cause_o), 32'd0);
    check("rst_alarm_pc", bus.alarm_pc_o, 32'd0);
    check("rst_depth", 32'(bus.depth_o), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Matched call/return.
    issue(1'b1, mk_jal(26'h10), 32'h1000, 32'h0);
    issue(1'b1, mk_jr(5'd9), 32'h1100, 32'h1008);
    wait_idle();

    // Mismatched return: alarm pulse three cycles after acceptance.
    issue(1'b1, mk_jal(26'h20), 32'h2000, 32'h0);
    issue(1'b1, mk_jr(5'd9), 32'h2004, 32'hDEAD0000);
    repeat (3) @(negedge clk);
    check("mismatch_early", 32'(bus.alarm_o), 32'd0);
    @(negedge clk);
    check("mismatch_alarm", 32'(bus.alarm_o), 32'd1);
    check("mismatch_busy_low", 32'(bus.busy_o), 32'd0);
    wait_idle();

    // Underflow at depth 0.
    issue(1'b1, mk_jr(5'd9), 32'h3000, 32'h3008);
    @(negedge clk);
    check("underflow_alarm", 32'(bus.alarm_o), 32'd1);
    check("underflow_no_pop", 32'(bus.stk_en_o), 32'd0);
    check("underflow_no_busy", 32'(bus.busy_o), 32'd0);

    // Fill to capacity, then overflow.
    for (int i = 0; i < 128; i++) issue(1'b1, mk_jalr(5'(i)), 32'h4000 + 32'(i * 4), 32'h0);
    @(negedge clk);
    check("full_depth", 32'(bus.depth_o), 32'd128);
    issue(1'b1, mk_jal(26'h3), 32'h5000, 32'h0);
    @(negedge clk);
    check("overflow_alarm", 32'(bus.alarm_o), 32'd1);
    check("overflow_no_push", 32'(bus.stk_en_o), 32'd0);
    check("overflow_depth", 32'(bus.depth_o), 32'd128);
    for (int i = 0; i < 128; i++) begin
      issue(1'b1, mk_jr(5'd9), 32'h6000 + 32'(i * 4), top_or_zero());
      wait_idle();
    end

    // Nested calls interleaved with l.jr r3, returns in LIFO order.
    issue(1'b1, mk_jal(26'h1), 32'h7000, 32'h0);
    issue(1'b1, mk_jalr(5'd4), 32'h7100, 32'h0);
    issue(1'b1, mk_jr(5'd3), 32'h7200, 32'h1234);
    issue(1'b1, mk_jal(26'h2), 32'h7300, 32'h0);
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, mk_jr(5'd9), 32'h7400 + 32'(i * 4), top_or_zero());
      wait_idle();
      issue(1'b1, mk_jr(5'd3), 32'h7500 + 32'(i * 4), 32'h0);
    end

    // Randomized stream, including instructions offered while stalled.
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 9);
      pc = $urandom & 32'hFFFF_FFFC;
      case (r)
        0, 1:    issue(1'b1, mk_jal(26'($urandom)), pc, 32'($urandom));
        2, 3:    issue(1'b1, mk_jalr(5'($urandom)), pc, 32'($urandom));
        4, 5, 6: issue(1'b1, mk_jr(5'd9), pc,
                       ($urandom_range(0, 3) != 0) ? top_or_zero() : 32'($urandom));
        7:       issue(1'b1, mk_jr(5'd3), pc, 32'($urandom));
        8:       issue(1'b1, {6'($urandom_range(32, 63)), 26'($urandom)}, pc, 32'($urandom));
        default: issue(1'b0, 32'($urandom), pc, 32'($urandom));
      endcase
    end
    wait_idle();

    // Reset while the pop is in WAIT.
    issue(1'b1, mk_jal(26'h5), 32'h8000, 32'h0);
    issue(1'b1, mk_jr(5'd9), 32'h8004, top_or_zero());
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    mstk.delete();
    exp_op.delete();
    exp_al.delete();
    @(negedge clk);
    check("rstwait_busy", 32'(bus.busy_o), 32'd0);
    check("rstwait_depth", 32'(bus.depth_o), 32'd0);
    check("rstwait_alarm", 32'(bus.alarm_o), 32'd0);
    check("rstwait_stk_en", 32'(bus.stk_en_o), 32'd0);
    repeat (6) @(negedge clk);
    check("rstwait_later_busy", 32'(bus.busy_o), 32'd0);

    check("ops_drained", 32'(exp_op.size()), 32'd0);
    check("alarms_drained", 32'(exp_al.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
